register_file: RTL and testbench



---
 rtl/s_machine_pkg.sv | 11 +
 rtl/rf_read_port.sv | 73 +++++++
 rtl/register_file.sv | 124 ++++++++++++
 tb/tb_register_file.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s_machine_pkg.sv
// Shared S-Machine types and sizing constants for the register file.
package s_machine_pkg;

  localparam int WORD_W    = 16;
  localparam int REG_DEPTH = 8;
  localparam int REG_AW    = $clog2(REG_DEPTH);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file: resolves range, zero-register,
// pending-hazard and write-bypass conditions and registers data/valid/stall.
module rf_read_port
  import s_machine_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = REG_DEPTH,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] word,
  input  logic             pend,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_stall
);

  logic             in_range;
  logic             is_zero;
  logic             use_bypass;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             stall_reg, stall_next;

  assign in_range   = (int'(addr) < DEPTH);
  assign is_zero    = (ZERO_REG != 0) && (addr == '0);
  // A same-cycle write only forwards when bypassing is built in.
  assign use_bypass = (BYPASS != 0) && wr_en && (wr_addr == addr);

  // Decide what this request returns; data holds unless a valid word is produced.
  always_comb begin
    data_next  = data_reg;
    valid_next = 1'b0;
    stall_next = 1'b0;
    if (rd_en) begin
      if (!in_range || is_zero) begin
        data_next  = '0;
        valid_next = 1'b1;
      end else if (pend && !use_bypass) begin
        stall_next = 1'b1;
      end else begin
        valid_next = 1'b1;
        data_next  = use_bypass ? wr_data : word;
      end
    end
  end

  // Output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      stall_reg <= 1'b0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
      stall_reg <= stall_next;
    end
  end

  assign rd_data  = data_reg;
  assign rd_valid = valid_reg;
  assign rd_stall = stall_reg;

endmodule

// File: rtl/register_file.sv
// S-Machine general-purpose register file: DEPTH x WIDTH storage, one write
// port, two registered read ports with optional bypass, and a pending-write
// scoreboard used by decode to detect read-after-write hazards.
module register_file
  import s_machine_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int DEPTH    = REG_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  output logic             rd_stall_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  output logic             rd_stall_b,
  output logic [DEPTH-1:0] pending,
  output logic             rsv_err
);

  logic [WIDTH-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0] pending_reg;
  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] rsv_sel;
  logic             rsv_err_reg;
  logic             rsv_conflict;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam bit IS_ZERO = (ZERO_REG != 0) && (gi == 0);

      // Out-of-range addresses never match any slot, so they are dropped here.
      assign wr_sel[gi]  = !IS_ZERO && wr_en  && (wr_addr  == AW'(gi));
      assign rsv_sel[gi] = !IS_ZERO && rsv_en && (rsv_addr == AW'(gi));

      // Register storage for slot gi.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          regs_reg[gi] <= '0;
        end else if (wr_sel[gi]) begin
          regs_reg[gi] <= wr_data;
        end
      end

      // Scoreboard bit: reserve sets it and wins over a same-cycle write.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_reg[gi] <= 1'b0;
        end else if (rsv_sel[gi]) begin
          pending_reg[gi] <= 1'b1;
        end else if (wr_sel[gi]) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Reserving a slot that is still pending and not being retired this cycle.
  assign rsv_conflict = |(rsv_sel & pending_reg & ~wr_sel);

  // Registered one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_err_reg <= 1'b0;
    end else begin
      rsv_err_reg <= rsv_conflict;
    end
  end

  assign pending = pending_reg;
  assign rsv_err = rsv_err_reg;

  logic [WIDTH-1:0] word_a, word_b;
  logic             pend_a, pend_b;

  // Fetch the addressed word and pending bit for each port, guarding the range.
  always_comb begin
    word_a = '0;
    pend_a = 1'b0;
    word_b = '0;
    pend_b = 1'b0;
    if (int'(rd_addr_a) < DEPTH) begin
      word_a = regs_reg[rd_addr_a];
      pend_a = pending_reg[rd_addr_a];
    end
    if (int'(rd_addr_b) < DEPTH) begin
      word_b = regs_reg[rd_addr_b];
      pend_b = pending_reg[rd_addr_b];
    end
  end

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_a (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en_a), .addr(rd_addr_a), .word(word_a), .pend(pend_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_stall(rd_stall_a)
  );

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port_b (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en_b), .addr(rd_addr_b), .word(word_b), .pend(pend_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_stall(rd_stall_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a default build (DEPTH=8, BYPASS=1) and
// a DEPTH=6, ZERO_REG=1, BYPASS=0 build, driven with directed vectors.
module tb_register_file;
  import s_machine_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Build 1: defaults
  logic      wr_en1, rsv_en1, rd_en_a1, rd_en_b1;
  reg_addr_t wr_addr1, rsv_addr1, rd_addr_a1, rd_addr_b1;
  word_t     wr_data1, rd_data_a1, rd_data_b1;
  logic      rd_valid_a1, rd_stall_a1, rd_valid_b1, rd_stall_b1, rsv_err1;
  logic [7:0] pending1;

  // Build 2: DEPTH=6, ZERO_REG=1, BYPASS=0
  logic      wr_en2, rsv_en2, rd_en_a2, rd_en_b2;
  reg_addr_t wr_addr2, rsv_addr2, rd_addr_a2, rd_addr_b2;
  word_t     wr_data2, rd_data_a2, rd_data_b2;
  logic      rd_valid_a2, rd_stall_a2, rd_valid_b2, rd_stall_b2, rsv_err2;
  logic [5:0] pending2;

  register_file u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rsv_en(rsv_en1), .rsv_addr(rsv_addr1),
    .rd_en_a(rd_en_a1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1),
    .rd_valid_a(rd_valid_a1), .rd_stall_a(rd_stall_a1),
    .rd_en_b(rd_en_b1), .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1),
    .rd_valid_b(rd_valid_b1), .rd_stall_b(rd_stall_b1),
    .pending(pending1), .rsv_err(rsv_err1)
  );

  register_file #(.DEPTH(6), .ZERO_REG(1), .BYPASS(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rsv_en(rsv_en2), .rsv_addr(rsv_addr2),
    .rd_en_a(rd_en_a2), .rd_addr_a(rd_addr_a2), .rd_data_a(rd_data_a2),
    .rd_valid_a(rd_valid_a2), .rd_stall_a(rd_stall_a2),
    .rd_en_b(rd_en_b2), .rd_addr_b(rd_addr_b2), .rd_data_b(rd_data_b2),
    .rd_valid_b(rd_valid_b2), .rd_stall_b(rd_stall_b2),
    .pending(pending2), .rsv_err(rsv_err2)
  );

  // Read channels: 0=dut1 A, 1=dut1 B, 2=dut2 A, 3=dut2 B
  logic [3:0] mon_valid, mon_stall;
  word_t      mon_data [4];
  assign mon_valid = {rd_valid_b2, rd_valid_a2, rd_valid_b1, rd_valid_a1};
  assign mon_stall = {rd_stall_b2, rd_stall_a2, rd_stall_b1, rd_stall_a1};
  assign mon_data[0] = rd_data_a1;
  assign mon_data[1] = rd_data_b1;
  assign mon_data[2] = rd_data_a2;
  assign mon_data[3] = rd_data_b2;

  typedef struct {
    int    due;
    logic  valid;
    logic  stall;
    word_t data;
  } exp_t;

  exp_t sb_q [4][$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the expected response when it falls due and compares.
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (sb_q[c].size() > 0 && sb_q[c][0].due <= cyc) begin
        e = sb_q[c].pop_front();
        n_total++;
        if (mon_valid[c] === e.valid && mon_stall[c] === e.stall && mon_data[c] === e.data) begin
          n_pass++;
          $display("read ch%0d cyc%0d: valid=%b stall=%b data=%h ok", c, cyc, mon_valid[c], mon_stall[c], mon_data[c]);
        end else begin
          $display("FAIL read ch%0d cyc%0d: got valid=%b stall=%b data=%h, want valid=%b stall=%b data=%h",
                   c, cyc, mon_valid[c], mon_stall[c], mon_data[c], e.valid, e.stall, e.data);
        end
      end else if (mon_valid[c] || mon_stall[c]) begin
        n_total++;
        $display("FAIL unexpected ch%0d cyc%0d: got valid=%b stall=%b, want no response",
                 c, cyc, mon_valid[c], mon_stall[c]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) begin
      n_pass++;
      $display("check %s: %h ok", name, act);
    end else begin
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic clear_inputs();
    wr_en1 = 0; wr_addr1 = '0; wr_data1 = '0; rsv_en1 = 0; rsv_addr1 = '0;
    rd_en_a1 = 0; rd_addr_a1 = '0; rd_en_b1 = 0; rd_addr_b1 = '0;
    wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0; rsv_en2 = 0; rsv_addr2 = '0;
    rd_en_a2 = 0; rd_addr_a2 = '0; rd_en_b2 = 0; rd_addr_b2 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic wr1(input reg_addr_t a, input word_t d);
    wr_en1 = 1; wr_addr1 = a; wr_data1 = d;
  endtask
  task automatic wr2(input reg_addr_t a, input word_t d);
    wr_en2 = 1; wr_addr2 = a; wr_data2 = d;
  endtask
  task automatic rsv1(input reg_addr_t a);
    rsv_en1 = 1; rsv_addr1 = a;
  endtask
  task automatic rsv2(input reg_addr_t a);
    rsv_en2 = 1; rsv_addr2 = a;
  endtask

  // Issue a read on channel c and queue the response due after the next edge.
  task automatic rd(input int c, input reg_addr_t a, input logic v, input logic s, input word_t d);
    exp_t e;
    case (c)
      0: begin rd_en_a1 = 1; rd_addr_a1 = a; end
      1: begin rd_en_b1 = 1; rd_addr_b1 = a; end
      2: begin rd_en_a2 = 1; rd_addr_a2 = a; end
      default: begin rd_en_b2 = 1; rd_addr_b2 = a; end
    endcase
    e.due = cyc + 1; e.valid = v; e.stall = s; e.data = d;
    sb_q[c].push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset rd_data_a", 32'(rd_data_a1), 32'h0);
    chk("reset rd_valid_a", 32'(rd_valid_a1), 32'h0);
    chk("reset pending", 32'(pending1), 32'h0);
    chk("reset rsv_err", 32'(rsv_err1), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read back every register through both ports
    for (int i = 0; i < 8; i++) begin
      wr1(reg_addr_t'(i), word_t'(16'hA5A0 + i));
      step();
    end
    for (int i = 0; i < 8; i++) begin
      rd(0, reg_addr_t'(i), 1, 0, word_t'(16'hA5A0 + i));
      rd(1, reg_addr_t'(7 - i), 1, 0, word_t'(16'hA5A0 + 7 - i));
      step();
    end

    // Bypass: same-cycle write forwarded to both ports
    wr1(3'd2, 16'h0001); step();
    wr1(3'd2, 16'hBEEF); rd(0, 3'd2, 1, 0, 16'hBEEF); rd(1, 3'd2, 1, 0, 16'hBEEF); step();
    rd(0, 3'd2, 1, 0, 16'hBEEF); step();

    // Hazard: reserved register stalls until written
    rsv1(3'd4); step();
    chk("pending after rsv r4", 32'(pending1), 32'h10);
    rd(0, 3'd4, 0, 1, 16'hBEEF); step();
    wr1(3'd4, 16'h00C3); rd(0, 3'd4, 1, 0, 16'h00C3); step();
    chk("pending after wr r4", 32'(pending1), 32'h0);
    rd(1, 3'd4, 1, 0, 16'h00C3); step();

    // Reserve edge cases
    rsv1(3'd6); step();
    chk("rsv r6 first err", 32'(rsv_err1), 32'h0);
    chk("rsv r6 first pending", 32'(pending1), 32'h40);
    rsv1(3'd6); step();
    chk("rsv r6 second err", 32'(rsv_err1), 32'h1);
    chk("rsv r6 second pending", 32'(pending1), 32'h40);
    step();
    chk("rsv_err pulse ends", 32'(rsv_err1), 32'h0);
    wr1(3'd6, 16'h7777); rsv1(3'd6); step();
    chk("wr+rsv r6 pending", 32'(pending1), 32'h40);
    chk("wr+rsv r6 err", 32'(rsv_err1), 32'h0);

    // Reset mid-stream
    wr1(3'd3, 16'h1234); step();
    rsv1(3'd5); step();
    rsv1(3'd5); step();
    chk("pre-reset rsv_err", 32'(rsv_err1), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset rd_data_a", 32'(rd_data_a1), 32'h0);
    chk("midreset rd_data_b", 32'(rd_data_b1), 32'h0);
    chk("midreset pending", 32'(pending1), 32'h0);
    chk("midreset rsv_err", 32'(rsv_err1), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rd(0, 3'd3, 1, 0, 16'h0000); step();

    // Build 2: zero register, out-of-range, dual-port, no bypass
    wr2(3'd0, 16'hFFFF); rd(3, 3'd0, 1, 0, 16'h0000); step();
    rd(2, 3'd0, 1, 0, 16'h0000); step();
    wr2(3'd1, 16'h1111); step();
    rd(2, 3'd1, 1, 0, 16'h1111); rd(3, 3'd1, 1, 0, 16'h1111); step();
    wr2(3'd7, 16'hDEAD); step();
    rd(2, 3'd7, 1, 0, 16'h0000); rd(3, 3'd6, 1, 0, 16'h0000); step();
    rd(2, 3'd1, 1, 0, 16'h1111); step();
    rsv2(3'd7); step();
    chk("b2 rsv out-of-range", 32'(pending2), 32'h0);
    rsv2(3'd0); step();
    chk("b2 rsv r0 pending", 32'(pending2), 32'h0);
    chk("b2 rsv r0 err", 32'(rsv_err2), 32'h0);
    wr2(3'd2, 16'h0001); step();
    wr2(3'd2, 16'hBEEF); rd(2, 3'd2, 1, 0, 16'h0001); step();
    rd(2, 3'd2, 1, 0, 16'hBEEF); step();
    rsv2(3'd4); step();
    chk("b2 pending rsv r4", 32'(pending2), 32'h10);
    wr2(3'd4, 16'h00C3); rd(2, 3'd4, 0, 1, 16'hBEEF); step();
    chk("b2 pending wr r4", 32'(pending2), 32'h0);
    rd(2, 3'd4, 1, 0, 16'h00C3); step();

    step(); step();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("drained ch%0d", c), 32'(sb_q[c].size()), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
